// File: rtl/edge_gen_pkg.sv
// ---------------------------------------------------------------------------
// edge_gen_pkg
// Shared types and default widths for the edge_generator pulse-train
// transmitter and its sub-modules.
//   state_t    : transmitter FSM state (IDLE / HIGH / LOW)
//   DEF_LEN_W  : default width of the phase-length inputs and length counter
//   DEF_NUM_W  : default width of the pulse-count input and pulse counter
// ---------------------------------------------------------------------------
package edge_gen_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    HIGH = 2'd1,
    LOW  = 2'd2
  } state_t;

  localparam int DEF_LEN_W = 32'd8;
  localparam int DEF_NUM_W = 32'd8;

endpackage

// File: rtl/edge_gen_counter.sv
// ---------------------------------------------------------------------------
// edge_gen_counter
// Loadable saturating down-counter with a zero flag.
// Ports:
//   clk      in  1  clock (rising edge)
//   rst      in  1  synchronous active-high reset, clears the count
//   load     in  1  load load_val (has priority over dec)
//   load_val in  W  value to load
//   dec      in  1  decrement by one; holds at zero, never wraps
//   count    out W  current count (registered)
//   zero     out 1  count == 0
// ---------------------------------------------------------------------------
module edge_gen_counter #(
  parameter int W = 32'd8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         dec,
  output logic [W-1:0] count,
  output logic         zero
);

  localparam logic [W-1:0] CNT_ZERO = {W{1'b0}};
  localparam logic [W-1:0] CNT_ONE  = {{(W-1){1'b0}}, 1'b1};

  // Count register: load, saturating decrement, or hold
  always_ff @(posedge clk) begin
    if (rst) begin
      count <= CNT_ZERO;
    end else if (load) begin
      count <= load_val;
    end else if (dec && (count != CNT_ZERO)) begin
      count <= count - CNT_ONE;
    end else begin
      count <= count;
    end
  end

  assign zero = (count == CNT_ZERO);

endmodule

// File: rtl/edge_generator.sv
// ---------------------------------------------------------------------------
// edge_generator
// Programmable pulse-train transmitter. On an accepted start it drives
// signal_out high for high_len cycles and low for low_len cycles, repeated
// num_pulses times, then pulses done. Lengths of 0 behave as 1; a count of 0
// produces no waveform, only a done pulse.
// Ports:
//   clk, rst                 clock / synchronous active-high reset
//   start                    request, accepted only while busy=0
//   high_len, low_len        phase lengths (LEN_W), sampled at accept
//   num_pulses               pulse count (NUM_W), sampled at accept
//   signal_out               generated waveform (registered)
//   rising_edge/falling_edge first cycle of each high / low phase
//   busy                     train in progress
//   done                     one-cycle completion pulse
//   abort, aborted           present only when EDGE_GEN_ABORT_EN is defined
// Optional feature macro: EDGE_GEN_ABORT_EN
// ---------------------------------------------------------------------------
module edge_generator
  import edge_gen_pkg::*;
#(
  parameter int LEN_W = DEF_LEN_W,
  parameter int NUM_W = DEF_NUM_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [LEN_W-1:0] high_len,
  input  logic [LEN_W-1:0] low_len,
  input  logic [NUM_W-1:0] num_pulses,
`ifdef EDGE_GEN_ABORT_EN
  input  logic             abort,
  output logic             aborted,
`endif
  output logic             signal_out,
  output logic             rising_edge,
  output logic             falling_edge,
  output logic             busy,
  output logic             done
);

  localparam logic [LEN_W-1:0] LEN_ZERO = {LEN_W{1'b0}};
  localparam logic [LEN_W-1:0] LEN_ONE  = {{(LEN_W-1){1'b0}}, 1'b1};
  localparam logic [NUM_W-1:0] NUM_ZERO = {NUM_W{1'b0}};
  localparam logic [NUM_W-1:0] NUM_ONE  = {{(NUM_W-1){1'b0}}, 1'b1};

  // Effective length minus one; a programmed 0 acts as a 1-cycle phase.
  function automatic logic [LEN_W-1:0] len_minus_one(input logic [LEN_W-1:0] len);
    return (len == LEN_ZERO) ? LEN_ZERO : (len - LEN_ONE);
  endfunction

  state_t           state_r;
  logic [LEN_W-1:0] high_m1_r;
  logic [LEN_W-1:0] low_m1_r;

  logic             abort_hit_s;
  logic             last_pulse_s;
  logic             len_load_s;
  logic             len_dec_s;
  logic [LEN_W-1:0] len_val_s;
  logic [LEN_W-1:0] len_cnt_s;
  logic             len_zero_s;
  logic             rem_load_s;
  logic             rem_dec_s;
  logic [NUM_W-1:0] rem_val_s;
  logic [NUM_W-1:0] rem_cnt_s;
  logic             rem_zero_s;

  // Cycles left in the current phase
  edge_gen_counter #(.W(LEN_W)) u_len_cnt (
    .clk      (clk),
    .rst      (rst),
    .load     (len_load_s),
    .load_val (len_val_s),
    .dec      (len_dec_s),
    .count    (len_cnt_s),
    .zero     (len_zero_s)
  );

  // Pulses left in the train, including the one in progress
  edge_gen_counter #(.W(NUM_W)) u_rem_cnt (
    .clk      (clk),
    .rst      (rst),
    .load     (rem_load_s),
    .load_val (rem_val_s),
    .dec      (rem_dec_s),
    .count    (rem_cnt_s),
    .zero     (rem_zero_s)
  );

  // Counter control: load at phase starts, count down inside a phase
  always_comb begin
    len_load_s = 1'b0;
    len_dec_s  = 1'b0;
    len_val_s  = LEN_ZERO;
    rem_load_s = 1'b0;
    rem_dec_s  = 1'b0;
    rem_val_s  = NUM_ZERO;
`ifdef EDGE_GEN_ABORT_EN
    abort_hit_s = abort && (state_r != IDLE);
`else
    abort_hit_s = 1'b0;
`endif
    // An empty remaining count is treated as the last pulse so the train can never stall.
    last_pulse_s = (rem_cnt_s == NUM_ONE) || rem_zero_s;
    case (state_r)
      IDLE: begin
        if (start) begin
          len_load_s = 1'b1;
          len_val_s  = len_minus_one(high_len);
          rem_load_s = 1'b1;
          rem_val_s  = num_pulses;
        end else begin
          len_load_s = 1'b0;
        end
      end
      HIGH: begin
        if (abort_hit_s) begin
          len_load_s = 1'b0;
        end else if (len_zero_s) begin
          len_load_s = 1'b1;
          len_val_s  = low_m1_r;
        end else begin
          len_dec_s = 1'b1;
        end
      end
      LOW: begin
        if (abort_hit_s) begin
          len_load_s = 1'b0;
        end else if (len_zero_s) begin
          if (!last_pulse_s) begin
            len_load_s = 1'b1;
            len_val_s  = high_m1_r;
            rem_dec_s  = 1'b1;
          end else begin
            len_load_s = 1'b0;
          end
        end else begin
          len_dec_s = 1'b1;
        end
      end
      default: begin
        len_load_s = 1'b0;
      end
    endcase
  end

  // Main FSM with registered waveform, edge markers and status
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r      <= IDLE;
      high_m1_r    <= LEN_ZERO;
      low_m1_r     <= LEN_ZERO;
      signal_out   <= 1'b0;
      rising_edge  <= 1'b0;
      falling_edge <= 1'b0;
      busy         <= 1'b0;
      done         <= 1'b0;
`ifdef EDGE_GEN_ABORT_EN
      aborted      <= 1'b0;
`endif
    end else begin
      rising_edge  <= 1'b0;
      falling_edge <= 1'b0;
      done         <= 1'b0;
`ifdef EDGE_GEN_ABORT_EN
      aborted      <= 1'b0;
`endif
      if (abort_hit_s) begin
        state_r      <= IDLE;
        signal_out   <= 1'b0;
        falling_edge <= signal_out;
        busy         <= 1'b0;
        done         <= 1'b1;
`ifdef EDGE_GEN_ABORT_EN
        aborted      <= 1'b1;
`endif
      end else begin
        case (state_r)
          IDLE: begin
            if (start) begin
              high_m1_r <= len_minus_one(high_len);
              low_m1_r  <= len_minus_one(low_len);
              if (num_pulses == NUM_ZERO) begin
                done <= 1'b1;
              end else begin
                state_r     <= HIGH;
                signal_out  <= 1'b1;
                rising_edge <= 1'b1;
                busy        <= 1'b1;
              end
            end else begin
              state_r <= IDLE;
            end
          end
          HIGH: begin
            if (len_zero_s) begin
              state_r      <= LOW;
              signal_out   <= 1'b0;
              falling_edge <= 1'b1;
            end else begin
              state_r <= HIGH;
            end
          end
          LOW: begin
            if (len_zero_s) begin
              if (last_pulse_s) begin
                state_r <= IDLE;
                busy    <= 1'b0;
                done    <= 1'b1;
              end else begin
                state_r     <= HIGH;
                signal_out  <= 1'b1;
                rising_edge <= 1'b1;
              end
            end else begin
              state_r <= LOW;
            end
          end
          default: begin
            state_r    <= IDLE;
            signal_out <= 1'b0;
            busy       <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_edge_generator.sv
// ---------------------------------------------------------------------------
// tb_edge_generator
// Self-checking bench for edge_generator. The expected outputs come from a
// per-train timing model: given the accept cycle T and effective H, L, N,
// every output in cycle T+c follows directly from c. Stimulus is a directed
// prologue followed by randomized start/length/count/reset traffic.
// Abort stimulus is included when EDGE_GEN_ABORT_EN is defined.
// ---------------------------------------------------------------------------
module tb_edge_generator;

  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic [7:0] high_len;
  logic [7:0] low_len;
  logic [7:0] num_pulses;
  logic       signal_out;
  logic       rising_edge;
  logic       falling_edge;
  logic       busy;
  logic       done;
`ifdef EDGE_GEN_ABORT_EN
  logic       abort;
  logic       aborted;
`endif

  always #5 clk = ~clk;

  edge_generator dut (
    .clk          (clk),
    .rst          (rst),
    .start        (start),
    .high_len     (high_len),
    .low_len      (low_len),
    .num_pulses   (num_pulses),
`ifdef EDGE_GEN_ABORT_EN
    .abort        (abort),
    .aborted      (aborted),
`endif
    .signal_out   (signal_out),
    .rising_edge  (rising_edge),
    .falling_edge (falling_edge),
    .busy         (busy),
    .done         (done)
  );

  typedef struct packed {
    logic sig;
    logic rise;
    logic fall;
    logic bsy;
    logic dn;
    logic abrt;
  } exp_t;

  int   n_vec = 0;
  int   n_err = 0;
  int   cyc   = 0;
  exp_t exp_r = '0;
  bit   have_train = 1'b0;
  int   t_acc, m_h, m_l, m_n;

  task automatic check(input string tag, input logic [5:0] got, input logic [5:0] want);
    n_vec++;
    if (got !== want) begin
      n_err++;
      $display("FAIL %s cyc=%0d got{sig,rise,fall,busy,done,aborted}=%b want=%b", tag, cyc, got, want);
    end
  endtask

  // Expected outputs in cycle e for the current train
  function automatic exp_t model_at(input int e);
    exp_t r;
    int c, per, p;
    r = '0;
    if (have_train) begin
      c   = e - t_acc;
      per = m_h + m_l;
      if (m_n == 0) begin
        r.dn = (c == 1);
      end else if (c >= 1 && c <= m_n * per) begin
        p      = (c - 1) % per;
        r.bsy  = 1'b1;
        r.sig  = (p < m_h);
        r.rise = (p == 0);
        r.fall = (p == m_h);
      end else begin
        r.dn = (c == m_n * per + 1);
      end
    end
    return r;
  endfunction

  // Advance one clock, update the model with the sampled inputs, compare
  task automatic step();
    logic abort_in;
    logic prev_sig;
    logic [5:0] got;
`ifdef EDGE_GEN_ABORT_EN
    abort_in = abort;
`else
    abort_in = 1'b0;
`endif
    @(posedge clk);
    cyc++;
    prev_sig = exp_r.sig;
    if (rst) begin
      have_train = 1'b0;
      exp_r      = '0;
    end else if (start && !exp_r.bsy) begin
      have_train = 1'b1;
      t_acc      = cyc - 1;
      m_h        = (high_len == 8'd0) ? 1 : int'(high_len);
      m_l        = (low_len == 8'd0) ? 1 : int'(low_len);
      m_n        = int'(num_pulses);
      exp_r      = model_at(cyc);
    end else if (abort_in && exp_r.bsy) begin
      have_train = 1'b0;
      exp_r      = '0;
      exp_r.fall = prev_sig;
      exp_r.dn   = 1'b1;
      exp_r.abrt = 1'b1;
    end else begin
      exp_r = model_at(cyc);
    end
    #1;
`ifdef EDGE_GEN_ABORT_EN
    got = {signal_out, rising_edge, falling_edge, busy, done, aborted};
`else
    got = {signal_out, rising_edge, falling_edge, busy, done, 1'b0};
`endif
    check("outputs", got, exp_r);
  endtask

  // Present a start for one cycle, then scramble the inputs
  task automatic launch(input logic [7:0] h, input logic [7:0] l, input logic [7:0] n);
    start      = 1'b1;
    high_len   = h;
    low_len    = l;
    num_pulses = n;
    step();
    start      = 1'b0;
    high_len   = 8'($urandom);
    low_len    = 8'($urandom);
    num_pulses = 8'($urandom);
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  function automatic logic [7:0] rand_len();
    if ($urandom_range(0, 39) == 0) return 8'($urandom_range(200, 255));
    return 8'($urandom_range(0, 6));
  endfunction

  initial begin
    rst        = 1'b1;
    start      = 1'b0;
    high_len   = 8'd0;
    low_len    = 8'd0;
    num_pulses = 8'd0;
`ifdef EDGE_GEN_ABORT_EN
    abort      = 1'b0;
`endif
    // start during reset must be ignored
    run(2);
    start = 1'b1;
    num_pulses = 8'd1;
    run(1);
    start = 1'b0;
    rst   = 1'b0;
    run(2);

    // basic 3/2 x2 train
    launch(8'd3, 8'd2, 8'd2);
    run(12);
    // zero lengths act as 1
    launch(8'd0, 8'd0, 8'd3);
    run(8);
    // zero count: done only
    launch(8'd4, 8'd4, 8'd0);
    run(3);

    // start mid-train ignored, start in done cycle accepted
    launch(8'd2, 8'd1, 8'd2);
    run(1);
    start = 1'b1;
    run(1);
    start = 1'b0;
    for (int i = 0; i < 50 && !exp_r.dn; i++) step();
    launch(8'd2, 8'd2, 8'd1);
    run(6);

    // reset mid-train, then a normal train
    launch(8'd5, 8'd1, 8'd1);
    rst = 1'b1;
    run(1);
    rst = 1'b0;
    run(3);
    launch(8'd2, 8'd2, 8'd1);
    run(6);

`ifdef EDGE_GEN_ABORT_EN
    // abort while high, then abort+start together in idle
    launch(8'd4, 8'd4, 8'd3);
    run(1);
    abort = 1'b1;
    run(1);
    abort = 1'b0;
    run(2);
    abort      = 1'b1;
    start      = 1'b1;
    high_len   = 8'd1;
    low_len    = 8'd1;
    num_pulses = 8'd1;
    run(1);
    abort = 1'b0;
    start = 1'b0;
    run(4);
`endif

    // maximum length and maximum count
    launch(8'd255, 8'd0, 8'd2);
    run(515);
    launch(8'd1, 8'd1, 8'd255);
    run(515);

    // randomized traffic
    for (int i = 0; i < 3000; i++) begin
      start      = ($urandom_range(0, 7) == 0);
      high_len   = rand_len();
      low_len    = rand_len();
      num_pulses = ($urandom_range(0, 19) == 0) ? 8'($urandom_range(5, 20)) : 8'($urandom_range(0, 4));
      rst        = ($urandom_range(0, 299) == 0);
`ifdef EDGE_GEN_ABORT_EN
      abort      = ($urandom_range(0, 79) == 0);
`endif
      step();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
